// File: rtl/core2mem_pkg.sv
// Shared types for the core-to-memory arbiter: FSM states, operation kind,
// and the index-width helper used by the arbiter and the top.
package core2mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // A single port still needs a 1-bit index so the select logic stays uniform.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_ift.sv
// Memory-side bundle: read/write request channels from the master and the
// read-data / write-ack responses from the memory.
interface Mem_ift #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  typedef struct packed {
    logic [ADDR_W-1:0] raddr;
    logic              ren;
  } mr_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   waddr;
    logic                wen;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wmask;
  } mw_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
  } sr_t;

  typedef struct packed {
    logic wvalid;
  } sw_t;

  mr_t Mr;
  mw_t Mw;
  sr_t Sr;
  sw_t Sw;

  modport Master (output Mr, output Mw, input Sr, input Sw);
  modport Slave  (input Mr, input Mw, output Sr, output Sw);

endinterface

// File: rtl/core2mem_arb_fsm_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr_q and wraps; ptr_q moves to
// the port after the winner only when the caller accepts the grant.
module rr_arbiter
  import core2mem_pkg::*;
#(
  parameter  int NPORT = 2,
  localparam int IDX_W = idx_w(NPORT)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NPORT-1:0] req,
  input  logic             accept,
  output logic [NPORT-1:0] grant_oh,
  output logic [IDX_W-1:0] grant_idx
);

  localparam int         SUM_W = IDX_W + 1;
  localparam logic [SUM_W-1:0] NP = SUM_W'(NPORT);

  logic [IDX_W-1:0] ptr_q;
  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NPORT; k++) begin
      sum = {1'b0, ptr_q} + SUM_W'(k);
      if (sum >= NP) sum = sum - NP;
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_idx      = cand;
        grant_oh[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (grant_idx == IDX_W'(NPORT - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/core2mem_arb_fsm.sv
// Arbitrates NPORT core request ports onto one memory master, one transaction
// at a time: IDLE grants and latches, BUSY waits for the response, DONE releases.
module core2mem_arb_fsm
  import core2mem_pkg::*;
#(
  parameter  int NPORT  = 2,
  parameter  int ADDR_W = 64,
  parameter  int DATA_W = 64,
  localparam int MASK_W = DATA_W / 8,
  localparam int IDX_W  = idx_w(NPORT)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NPORT-1:0][ADDR_W-1:0]   address_cpu,
  input  logic [NPORT-1:0]               wen_cpu,
  input  logic [NPORT-1:0]               ren_cpu,
  input  logic [NPORT-1:0][DATA_W-1:0]   wdata_cpu,
  input  logic [NPORT-1:0][MASK_W-1:0]   wmask_cpu,
  output logic [NPORT-1:0][DATA_W-1:0]   rdata_cpu,
  output logic [NPORT-1:0]               mem_stall,
  output state_t                         state_dbg,
  Mem_ift.Master                         mem_ift
);

  state_t                         state_q, state_d;
  op_t                            op_q;
  logic [IDX_W-1:0]               grant_q;
  logic [ADDR_W-1:0]              addr_q;
  logic [DATA_W-1:0]              wdata_q;
  logic [MASK_W-1:0]              wmask_q;
  logic [NPORT-1:0][DATA_W-1:0]   rdata_q;

  logic [NPORT-1:0] req;
  logic [NPORT-1:0] arb_oh;
  logic [IDX_W-1:0] arb_idx;
  logic [NPORT-1:0] done_oh;
  logic             accept;
  logic             rd_hit;
  logic             wr_hit;

  assign req    = wen_cpu | ren_cpu;
  assign accept = (state_q == IDLE) && (|req);
  assign rd_hit = (state_q == BUSY) && (op_q == OP_RD) && mem_ift.Sr.rvalid;
  assign wr_hit = (state_q == BUSY) && (op_q == OP_WR) && mem_ift.Sw.wvalid;

  rr_arbiter #(.NPORT(NPORT)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .accept    (accept),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (rd_hit || wr_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write wins when both enables are high on the granted port.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_q    <= OP_RD;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= (|(wen_cpu & arb_oh)) ? OP_WR : OP_RD;
        grant_q <= arb_idx;
        addr_q  <= address_cpu[arb_idx];
        wdata_q <= wdata_cpu[arb_idx];
        wmask_q <= wmask_cpu[arb_idx];
      end
      if (rd_hit) rdata_q[grant_q] <= mem_ift.Sr.rdata;
    end
  end

  // Memory-side outputs come only from the latches and state.
  always_comb begin
    mem_ift.Mr.raddr = addr_q;
    mem_ift.Mr.ren   = (state_q == BUSY) && (op_q == OP_RD);
    mem_ift.Mw.waddr = addr_q;
    mem_ift.Mw.wen   = (state_q == BUSY) && (op_q == OP_WR);
    mem_ift.Mw.wdata = wdata_q;
    mem_ift.Mw.wmask = wmask_q;
    done_oh          = '0;
    if (state_q == DONE) done_oh[grant_q] = 1'b1;
    mem_stall        = req & ~done_oh;
    rdata_cpu        = rdata_q;
    state_dbg        = state_q;
  end

endmodule

// File: tb/tb_core2mem_arb_fsm.sv
// Bench for core2mem_arb_fsm: directed scenarios then randomized traffic, all
// checked each cycle against a transaction-level model of the arbiter.
module tb_core2mem_arb_fsm;

  localparam int NP = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic rstn;
  logic [NP-1:0][AW-1:0] address_cpu;
  logic [NP-1:0]         wen_cpu;
  logic [NP-1:0]         ren_cpu;
  logic [NP-1:0][DW-1:0] wdata_cpu;
  logic [NP-1:0][MW-1:0] wmask_cpu;
  logic [NP-1:0][DW-1:0] rdata_cpu;
  logic [NP-1:0]         mem_stall;
  core2mem_pkg::state_t  state_dbg;

  Mem_ift #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  core2mem_arb_fsm #(.NPORT(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .address_cpu (address_cpu),
    .wen_cpu     (wen_cpu),
    .ren_cpu     (ren_cpu),
    .wdata_cpu   (wdata_cpu),
    .wmask_cpu   (wmask_cpu),
    .rdata_cpu   (rdata_cpu),
    .mem_stall   (mem_stall),
    .state_dbg   (state_dbg),
    .mem_ift     (mif)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding transaction; m_issued = request on the memory bus,
  // m_release = the single cycle the owner's stall is lifted.
  bit            m_issued, m_release, m_wr;
  int            m_port, m_next;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;
  logic [DW-1:0] m_rd [NP];

  task automatic model_reset();
    m_issued = 0; m_release = 0; m_wr = 0; m_port = 0; m_next = 0;
    m_addr = '0; m_wdata = '0; m_wmask = '0;
    for (int i = 0; i < NP; i++) m_rd[i] = '0;
    exp_q.delete();
  endtask

  function automatic bit exp_stall(input int i);
    return (wen_cpu[i] | ren_cpu[i]) && !(m_release && m_port == i);
  endfunction

  task automatic model_edge();
    if (!rstn) begin
      model_reset();
    end else if (m_release) begin
      m_release = 0;
    end else if (m_issued) begin
      if (!m_wr && mif.Sr.rvalid) begin
        m_rd[m_port] = mif.Sr.rdata;
        exp_q.push_back(mif.Sr.rdata);
        m_issued = 0; m_release = 1;
      end else if (m_wr && mif.Sw.wvalid) begin
        m_issued = 0; m_release = 1;
      end
    end else begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_next + k) % NP;
        if (!m_issued && (wen_cpu[p] | ren_cpu[p])) begin
          m_issued = 1;
          m_port   = p;
          m_wr     = wen_cpu[p];
          m_addr   = address_cpu[p];
          m_wdata  = wdata_cpu[p];
          m_wmask  = wmask_cpu[p];
          m_next   = (p + 1) % NP;
        end
      end
    end
  endtask

  // Compare this cycle's outputs, advance the model over the edge, land on negedge.
  task automatic tick();
    #1;
    for (int i = 0; i < NP; i++) begin
      check($sformatf("stall%0d", i), 64'(mem_stall[i]), 64'(exp_stall(i)));
      check($sformatf("rdata%0d", i), rdata_cpu[i], m_rd[i]);
    end
    check("ren",   64'(mif.Mr.ren), 64'(m_issued && !m_wr));
    check("wen",   64'(mif.Mw.wen), 64'(m_issued && m_wr));
    check("raddr", mif.Mr.raddr, m_addr);
    check("waddr", mif.Mw.waddr, m_addr);
    check("wdata", mif.Mw.wdata, m_wdata);
    check("wmask", 64'(mif.Mw.wmask), 64'(m_wmask));
    if (m_release && !m_wr && exp_q.size() > 0)
      check("rd_done", rdata_cpu[m_port], exp_q.pop_front());
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_port(input int i, input bit w, input bit r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [MW-1:0] m);
    wen_cpu[i] = w; ren_cpu[i] = r; address_cpu[i] = a; wdata_cpu[i] = d; wmask_cpu[i] = m;
  endtask

  task automatic set_mem(input bit rv, input logic [DW-1:0] rd, input bit wv);
    mif.Sr.rvalid = rv; mif.Sr.rdata = rd; mif.Sw.wvalid = wv;
  endtask

  task automatic clear_ports();
    for (int i = 0; i < NP; i++) set_port(i, 0, 0, '0, '0, '0);
  endtask

  task automatic rand_cycle();
    for (int i = 0; i < NP; i++) begin
      if ((wen_cpu[i] | ren_cpu[i]) && exp_stall(i) && $urandom_range(0, 15) != 0) continue;
      if ($urandom_range(0, 1) != 0) begin
        int op;
        op = $urandom_range(0, 3);
        set_port(i, op >= 2, op != 2, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                 MW'($urandom()));
      end else begin
        set_port(i, 0, 0, address_cpu[i], wdata_cpu[i], wmask_cpu[i]);
      end
    end
    set_mem($urandom_range(0, 2) == 0, {$urandom(), $urandom()}, $urandom_range(0, 2) == 0);
    rstn = ($urandom_range(0, 199) != 0);
    tick();
  endtask

  // ---------------- sequence ----------------
  initial begin
    rstn = 1'b0;
    clear_ports();
    set_mem(0, '0, 0);
    model_reset();
    @(negedge clk);
    tick(); tick();
    rstn = 1'b1;

    // Spurious responses while idle.
    set_mem(1, 64'hBAD0_BAD0_BAD0_BAD0, 1);
    tick(); tick();
    set_mem(0, '0, 0);

    // Single read on port 0, response in the second BUSY cycle.
    set_port(0, 0, 1, 64'h80, '0, '0);
    tick(); tick();
    set_mem(1, 64'hDEADBEEF, 1);
    tick();
    set_mem(0, '0, 0);
    #1 check("req034_rdata", rdata_cpu[0], 64'hDEADBEEF);
    check("req034_stall_low", 64'(mem_stall[0]), 64'h0);
    tick();
    clear_ports();
    tick();

    // Ports 0 and 1 reading continuously: grants must alternate.
    set_port(0, 0, 1, 64'h1000, '0, '0);
    set_port(1, 0, 1, 64'h2000, '0, '0);
    for (int c = 0; c < 24; c++) begin
      set_mem(c % 3 == 1, {32'h0, 32'(c)}, 0);
      tick();
    end
    clear_ports();
    set_mem(0, '0, 0);
    tick(); tick(); tick();

    // Port 1 write with rvalid noise during BUSY.
    set_port(1, 1, 0, 64'h100, 64'h1122334455667788, 8'h0F);
    tick();
    set_mem(1, 64'hFFFF, 0);
    tick();
    set_mem(1, 64'hFFFF, 1);
    tick();
    set_mem(0, '0, 0);
    tick();
    clear_ports();
    tick(); tick();

    // Port 0 with both enables: must be a write.
    set_port(0, 1, 1, 64'h40, 64'hA5A5, 8'hFF);
    tick(); tick();
    set_mem(1, 64'h1, 1);
    tick();
    set_mem(0, '0, 0);
    tick();
    clear_ports();
    tick(); tick();

    // Reset mid-BUSY, then a late rvalid.
    set_port(2, 0, 1, 64'h300, '0, '0);
    tick(); tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    clear_ports();
    set_mem(1, 64'h5555, 0);
    tick();
    set_mem(0, '0, 0);
    tick(); tick();

    for (int c = 0; c < 3000; c++) rand_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
